// File: rtl/sevenseg_pkg.sv
// Shared constants and scan state encoding for the 7-segment scan controller.
package sevenseg_pkg;

    localparam logic [3:0] SEG_CODE_CHECK = 4'd10;
    localparam logic [3:0] SEG_CODE_X     = 4'd11;
    localparam logic [3:0] SEG_CODE_OFF   = 4'd12;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_SHOW
    } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Host-side register/commit bus of the scan controller.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                          wr_en;
    logic [$clog2(NUM_DIGITS)-1:0] wr_idx;
    logic [3:0]                    wr_val;
    logic                          commit;
    logic                          lz_suppress;
    logic [NUM_DIGITS-1:0]         blink_mask;
    logic                          commit_pending;

    modport master (
        output wr_en, wr_idx, wr_val, commit, lz_suppress, blink_mask,
        input  commit_pending
    );

    modport slave (
        input  wr_en, wr_idx, wr_val, commit, lz_suppress, blink_mask,
        output commit_pending
    );
endinterface

// File: rtl/sevenseg_driver.sv
// Combinational code-to-segment decoder, bit order {g,f,e,d,c,b,a}.
module sevenseg_driver
    import sevenseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b0000000;
        case (code)
            4'd0:           seg = 7'b0111111;
            4'd1:           seg = 7'b0000110;
            4'd2:           seg = 7'b1011011;
            4'd3:           seg = 7'b1001111;
            4'd4:           seg = 7'b1100110;
            4'd5:           seg = 7'b1101101;
            4'd6:           seg = 7'b1111101;
            4'd7:           seg = 7'b0000111;
            4'd8:           seg = 7'b1111111;
            4'd9:           seg = 7'b1101111;
            SEG_CODE_CHECK: seg = 7'b0011110;
            SEG_CODE_X:     seg = 7'b1110110;
            default:        seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with shadowed digit codes,
// frame-aligned commit, leading-zero suppression and per-digit blinking.
//
// state      | meaning
// SCAN_BLANK | all digits off, anti-ghosting gap before digit idx
// SCAN_SHOW  | digit idx driven with its decoded code
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sevenseg_scan_ctrl_if.slave    host,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  dig_en,
    output logic                   frame_start
);

    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    scan_state_t           state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic                  boundary;

    logic [3:0]            active [NUM_DIGITS];
    logic [3:0]            shadow [NUM_DIGITS];
    logic                  pending;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;

    logic                  wr_ok;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_above;
    logic [3:0]            disp_code;
    logic [6:0]            drv_seg;
    logic [NUM_DIGITS-1:0] onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCAN_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        boundary  = 1'b0;
        case (state)
            SCAN_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SCAN_SHOW;
                    cnt_nxt   = '0;
                end
            end
            SCAN_SHOW: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = SCAN_BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SCAN_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Out-of-range slot indices can only occur for non-power-of-two digit counts.
    if ((1 << IW) == NUM_DIGITS) begin : g_wr_full
        assign wr_ok = host.wr_en;
    end else begin : g_wr_part
        assign wr_ok = host.wr_en && ({1'b0, host.wr_idx} < (IW + 1)'(NUM_DIGITS));
    end

    // Digit i is a leading zero when it and every more significant digit hold 0.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above && (active[i] == 4'd0);
            lz_mask[i] = zero_above;
        end
    end

    always_comb begin
        disp_code = active[idx];
        if (host.lz_suppress && lz_mask[idx])
            disp_code = SEG_CODE_OFF;
        if (blink_phase && host.blink_mask[idx])
            disp_code = SEG_CODE_OFF;
    end

    sevenseg_driver u_driver (
        .code (disp_code),
        .seg  (drv_seg)
    );

    assign onehot              = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << idx;
    assign host.commit_pending = pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active[i] <= SEG_CODE_OFF;
                shadow[i] <= SEG_CODE_OFF;
            end
            pending     <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_start <= 1'b0;
            seg         <= '0;
            dig_en      <= '0;
        end else begin
            if (wr_ok)
                shadow[host.wr_idx] <= host.wr_val;

            // Transfer sees pre-edge shadow; a same-cycle write lands in shadow only.
            if (boundary && pending) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    active[i] <= shadow[i];
            end

            if (host.commit)
                pending <= 1'b1;
            else if (boundary)
                pending <= 1'b0;

            if (boundary) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            frame_start <= boundary;
            dig_en      <= (state == SCAN_SHOW) ? onehot  : '0;
            seg         <= (state == SCAN_SHOW) ? drv_seg : '0;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl (4 digits, 24-cycle frame).
module tb_sevenseg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] dig_en;
    logic       frame_start;

    int vectors     = 0;
    int miscompares = 0;
    int kcnt        = 0;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(4)) host ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // kcnt = number of rising edges since the last reset release
    task automatic tick();
        @(posedge clk);
        #1;
        kcnt++;
    endtask

    task automatic run_to(input int k);
        while (kcnt < k) tick();
    endtask

    task automatic write_reg(input logic [1:0] i, input logic [3:0] v);
        host.wr_en  = 1'b1;
        host.wr_idx = i;
        host.wr_val = v;
        tick();
        host.wr_en  = 1'b0;
    endtask

    task automatic pulse_commit();
        host.commit = 1'b1;
        tick();
        host.commit = 1'b0;
    endtask

    function automatic logic [3:0] exp_dig(input int k);
        int p;
        p = (k - 1) % 24;
        if ((p % 6) < 2) return 4'b0000;
        return 4'b0001 << (p / 6);
    endfunction

    function automatic int digit_of(input int k);
        return ((k - 1) % 24) / 6;
    endfunction

    function automatic bit shown(input int k);
        return ((k - 1) % 6) >= 2;
    endfunction

    task automatic test_reset();
        rst_n            = 1'b0;
        host.wr_en       = 1'b0;
        host.wr_idx      = '0;
        host.wr_val      = '0;
        host.commit      = 1'b0;
        host.lz_suppress = 1'b0;
        host.blink_mask  = '0;
        repeat (3) tick();
        vectors++;
        if (seg !== 7'd0 || dig_en !== 4'd0 || frame_start !== 1'b0 || host.commit_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL reset seg=%b dig_en=%b fs=%b pend=%b expected all zero",
                     seg, dig_en, frame_start, host.commit_pending);
        end
        rst_n = 1'b1;
        kcnt  = 0;
    endtask

    task automatic test_scan();
        repeat (50) begin
            tick();
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== 7'd0 || frame_start !== (kcnt % 24 == 0)
                || host.commit_pending !== 1'b0) begin
                miscompares++;
                $display("FAIL scan k=%0d dig_en=%b seg=%b fs=%b pend=%b expected dig_en=%b seg=0 fs=%0d pend=0",
                         kcnt, dig_en, seg, frame_start, host.commit_pending, exp_dig(kcnt), (kcnt % 24 == 0));
            end
        end
    endtask

    task automatic test_commit();
        logic [6:0] tab [4];
        logic [6:0] es;
        tab[0] = 7'b0111111; tab[1] = 7'b0000110; tab[2] = 7'b1011011; tab[3] = 7'b1001111;
        write_reg(2'd3, 4'd3);
        write_reg(2'd2, 4'd2);
        write_reg(2'd1, 4'd1);
        write_reg(2'd0, 4'd0);
        pulse_commit();
        vectors++;
        if (host.commit_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_set k=%0d pend=%b expected 1", kcnt, host.commit_pending);
        end
        while (kcnt < 72) begin
            tick();
            vectors++;
            if (host.commit_pending !== (kcnt < 72)) begin
                miscompares++;
                $display("FAIL commit_hold k=%0d pend=%b expected %0d", kcnt, host.commit_pending, (kcnt < 72));
            end
        end
        repeat (24) begin
            tick();
            es = shown(kcnt) ? tab[digit_of(kcnt)] : 7'd0;
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== es) begin
                miscompares++;
                $display("FAIL commit_frame k=%0d dig_en=%b seg=%b expected dig_en=%b seg=%b",
                         kcnt, dig_en, seg, exp_dig(kcnt), es);
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] tab [4];
        logic [6:0] es;
        host.lz_suppress = 1'b1;
        write_reg(2'd3, 4'd0);
        write_reg(2'd2, 4'd7);
        write_reg(2'd1, 4'd0);
        write_reg(2'd0, 4'd0);
        pulse_commit();
        run_to(120);
        tab[0] = 7'b0111111; tab[1] = 7'b0111111; tab[2] = 7'b0000111; tab[3] = 7'b0000000;
        repeat (24) begin
            tick();
            es = shown(kcnt) ? tab[digit_of(kcnt)] : 7'd0;
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== es) begin
                miscompares++;
                $display("FAIL lz_mixed k=%0d dig_en=%b seg=%b expected dig_en=%b seg=%b",
                         kcnt, dig_en, seg, exp_dig(kcnt), es);
            end
        end
        write_reg(2'd2, 4'd0);
        pulse_commit();
        run_to(168);
        tab[2] = 7'b0000000; tab[1] = 7'b0000000;
        repeat (24) begin
            tick();
            es = shown(kcnt) ? tab[digit_of(kcnt)] : 7'd0;
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== es) begin
                miscompares++;
                $display("FAIL lz_zeros k=%0d dig_en=%b seg=%b expected dig_en=%b seg=%b",
                         kcnt, dig_en, seg, exp_dig(kcnt), es);
            end
        end
        host.lz_suppress = 1'b0;
    endtask

    task automatic test_blink();
        logic [6:0] es;
        int         ph;
        write_reg(2'd0, 4'd10);
        pulse_commit();
        host.blink_mask = 4'b0001;
        run_to(216);
        repeat (48) begin
            tick();
            ph = (((kcnt - 1) / 24) / 2) % 2;
            if (!shown(kcnt))           es = 7'd0;
            else if (digit_of(kcnt) == 0) es = (ph == 1) ? 7'b0000000 : 7'b0011110;
            else                        es = 7'b0111111;
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== es) begin
                miscompares++;
                $display("FAIL blink k=%0d dig_en=%b seg=%b expected dig_en=%b seg=%b",
                         kcnt, dig_en, seg, exp_dig(kcnt), es);
            end
        end
        host.blink_mask = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [6:0] d0;
        logic [6:0] es;
        write_reg(2'd0, 4'd5);
        run_to(287);
        host.commit = 1'b1;
        tick();
        host.commit = 1'b0;
        vectors++;
        if (host.commit_pending !== 1'b1 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_commit k=%0d pend=%b fs=%b expected pend=1 fs=1",
                     kcnt, host.commit_pending, frame_start);
        end
        for (int f = 12; f <= 14; f++) begin
            d0 = (f == 12) ? 7'b0011110 : (f == 13) ? 7'b1101101 : 7'b1110110;
            run_to(24 * f);
            repeat (24) begin
                if (kcnt == 311) begin
                    host.wr_en  = 1'b1;
                    host.wr_idx = 2'd0;
                    host.wr_val = 4'd11;
                end
                if (kcnt == 312) host.commit = 1'b1;
                tick();
                host.wr_en  = 1'b0;
                host.commit = 1'b0;
                if (!shown(kcnt))             es = 7'd0;
                else if (digit_of(kcnt) == 0) es = d0;
                else                          es = 7'b0111111;
                vectors++;
                if (dig_en !== exp_dig(kcnt) || seg !== es) begin
                    miscompares++;
                    $display("FAIL b2b_frame%0d k=%0d dig_en=%b seg=%b expected dig_en=%b seg=%b",
                             f, kcnt, dig_en, seg, exp_dig(kcnt), es);
                end
                if (kcnt == 312) begin
                    vectors++;
                    if (host.commit_pending !== 1'b0) begin
                        miscompares++;
                        $display("FAIL transfer_clear k=%0d pend=%b expected 0", kcnt, host.commit_pending);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        pulse_commit();
        run_to(375);
        vectors++;
        if (dig_en !== 4'b0100 || host.commit_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset k=%0d dig_en=%b pend=%b expected dig_en=0100 pend=1",
                     kcnt, dig_en, host.commit_pending);
        end
        rst_n = 1'b0;
        tick();
        vectors++;
        if (dig_en !== 4'd0 || host.commit_pending !== 1'b0 || seg !== 7'd0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset dig_en=%b pend=%b seg=%b fs=%b expected all zero",
                     dig_en, host.commit_pending, seg, frame_start);
        end
        rst_n = 1'b1;
        kcnt  = 0;
        repeat (30) begin
            tick();
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== 7'd0 || host.commit_pending !== 1'b0
                || frame_start !== (kcnt % 24 == 0)) begin
                miscompares++;
                $display("FAIL restart k=%0d dig_en=%b seg=%b pend=%b fs=%b expected dig_en=%b seg=0 pend=0 fs=%0d",
                         kcnt, dig_en, seg, host.commit_pending, frame_start, exp_dig(kcnt), (kcnt % 24 == 0));
            end
        end
        // shadow must have been reset to off as well
        pulse_commit();
        run_to(48);
        repeat (24) begin
            tick();
            vectors++;
            if (dig_en !== exp_dig(kcnt) || seg !== 7'd0) begin
                miscompares++;
                $display("FAIL shadow_reset k=%0d dig_en=%b seg=%b expected dig_en=%b seg=0",
                         kcnt, dig_en, seg, exp_dig(kcnt));
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_commit();
        test_lz();
        test_blink();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
